mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL have `CLK`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have `RST`, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have `start`, input, 1 bit: operation request, sampled only in IDLE.
REQ-004 The block SHALL have `mduop`, input, 2 bits (`mdu_op_t`): MULT, MULTU, DIV or DIVU.
REQ-005 The block SHALL have `port_A` and `port_B`, inputs, 32 bits each: multiplicand/dividend and multiplier/divisor, sampled with `start`.
REQ-006 The block SHALL have `hi_wen` and `lo_wen`, inputs, 1 bit each, plus `wdata`, input, 32 bits: MTHI/MTLO writes.
REQ-007 The block SHALL have `busy`, output, 1 bit: an operation is in flight.
REQ-008 The block SHALL have `done`, output, 1 bit: one-cycle pulse when `hi`/`lo` take a new result.
REQ-009 The block SHALL have `hi` and `lo`, outputs, 32 bits each: architectural HI/LO registers.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, CALC and FIN.
REQ-011 In IDLE with `start`=1, the block SHALL latch operand magnitudes (two's-complement absolute value for MULT/DIV, raw for MULTU/DIVU), latch both sign bits and `mduop`, clear the iteration count, and enter CALC.
REQ-012 CALC SHALL perform one iteration per cycle: shift-add for multiply, restoring shift-subtract for divide; after the 32nd iteration it SHALL enter FIN.
REQ-013 FIN SHALL apply the sign fixup, write `hi`/`lo`, pulse `done` for that cycle, and return to IDLE.
REQ-014 Latency: with `start` seen at edge 0, `done`=1 SHALL be during cycle 33, with new `hi`/`lo` visible from edge 33.
REQ-015 `busy` SHALL be 1 in CALC and FIN and 0 in IDLE.
REQ-016 `start` while `busy`=1 SHALL be ignored, with no queuing.
REQ-017 Multiply result: `{hi,lo}` SHALL be the 64-bit product; MULT SHALL negate the 64-bit magnitude when the operand signs differ.
REQ-018 Divide result: `lo` SHALL be the quotient and `hi` the remainder; the quotient SHALL be negated when signs differ (DIV only), and the remainder sign SHALL follow the dividend.
REQ-019 DIV of 0x80000000 by 0xFFFFFFFF SHALL give `lo`=0x80000000, `hi`=0, with no trap.
REQ-020 A divisor of 0 (DIV or DIVU) SHALL give `lo`=0xFFFFFFFF and `hi`=the original `port_A`, with normal latency.
REQ-021 In IDLE, `hi_wen`/`lo_wen` SHALL load `wdata` into `hi`/`lo` at the next edge; both MAY be asserted in the same cycle.
REQ-022 `hi_wen`/`lo_wen` SHALL be ignored while `busy`=1.
REQ-023 If `start` and a write occur together in IDLE, the operation SHALL start and the write SHALL be discarded.

Reset
REQ-024 `RST`=1 at an edge SHALL force IDLE with `busy`=0, `done`=0, `hi`=0, `lo`=0, count=0, from any state.
REQ-025 Reset mid-operation SHALL abort the operation without producing a `done` pulse.
REQ-026 `start` asserted in the same cycle as `RST` SHALL be ignored.

Configuration
REQ-027 With `MDU_EARLY_OUT_EN` defined, MULT/MULTU SHALL leave CALC as soon as the remaining multiplier bits are all zero, with at least one CALC cycle; `done` SHALL then come one cycle after the exit.
REQ-028 With `MDU_EARLY_OUT_EN` defined, divide latency SHALL be unchanged.
REQ-029 Without `MDU_EARLY_OUT_EN`, all operations SHALL take the fixed latency of REQ-014.

Structure
REQ-030 `mdu_op_t` (MDU_MULT=2'b00, MDU_MULTU=2'b01, MDU_DIV=2'b10, MDU_DIVU=2'b11) and `word_t` SHALL live in `cpu_types_pkg`.
REQ-031 The FSM state enum SHALL be local to `mdu`.
REQ-032 Ports SHALL be grouped in interface `mdu_if` with modport `mdu`.
REQ-033 The block SHALL have no sub-module; datapath and FSM SHALL be in one module of 150-300 lines.

Verification
REQ-034 MULT A=0xFFFFFFFE, B=3 -> `done` during cycle 33, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA.
REQ-035 MULTU A=0xFFFFFFFE, B=3 -> `hi`=0x00000002, `lo`=0xFFFFFFFA.
REQ-036 DIV A=0xFFFFFFF9 (-7), B=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
REQ-037 DIVU A=7, B=0 -> `lo`=0xFFFFFFFF, `hi`=7, latency 33.
REQ-038 MTHI 0x1234 in IDLE -> `hi`=0x1234; MTLO during `busy` -> `lo` unchanged; a second `start` at cycle 5 -> ignored.
REQ-039 `start` MULT, then `RST` at cycle 10 -> at edge 11 `busy`=0, `hi`/`lo`=0, and no `done` ever pulses.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg -- shared CPU datapath types.
//   word_t    : 32-bit machine word
//   mdu_op_t  : multiply/divide unit operation select
//   magnitude : two's-complement absolute value, or the raw value when the
//               operation is unsigned
//   op_is_signed / op_is_div : decode helpers for mdu_op_t
// ---------------------------------------------------------------------------
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_t;

  function automatic logic op_is_signed(input mdu_op_t op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  function automatic logic op_is_div(input mdu_op_t op);
    return op[1];
  endfunction

  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic word_t magnitude(input word_t v, input logic is_signed);
    return (is_signed && v[WORD_W-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// ---------------------------------------------------------------------------
// mdu_if -- request/result bundle of the multiply/divide unit.
//   start, mduop, port_A, port_B : operation request and operands
//   hi_wen, lo_wen, wdata        : MTHI / MTLO writes
//   busy, done, hi, lo           : status and architectural HI/LO
// Modports: mdu (the unit itself), tb (the requester side).
// ---------------------------------------------------------------------------
interface mdu_if;
  import cpu_types_pkg::*;

  logic    start;
  mdu_op_t mduop;
  word_t   port_A;
  word_t   port_B;
  logic    hi_wen;
  logic    lo_wen;
  word_t   wdata;
  logic    busy;
  logic    done;
  word_t   hi;
  word_t   lo;

  modport mdu (
    input  start, mduop, port_A, port_B, hi_wen, lo_wen, wdata,
    output busy, done, hi, lo
  );

  modport tb (
    output start, mduop, port_A, port_B, hi_wen, lo_wen, wdata,
    input  busy, done, hi, lo
  );

endinterface

// File: rtl/mdu.sv
// ---------------------------------------------------------------------------
// mdu -- iterative 32x32 multiply / 32/32 divide unit with HI/LO registers.
//   CLK  : clock, all state changes on the rising edge
//   RST  : synchronous active-high reset
//   bus  : mdu_if.mdu (start/mduop/port_A/port_B request, MTHI/MTLO write,
//          busy/done status, hi/lo results)
// Operation: IDLE latches operand magnitudes, CALC does one shift-add
// (multiply) or restoring shift-subtract (divide) step per cycle for 32
// cycles, FIN applies the sign fixup and writes hi/lo while pulsing done.
// Optional: define MDU_EARLY_OUT_EN to let multiplies leave CALC once the
// remaining multiplier bits are all zero (divide latency is unchanged).
// ---------------------------------------------------------------------------
module mdu
  import cpu_types_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  mdu_if.mdu   bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIN
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [5:0]  r_cnt;
  mdu_op_t     r_op;
  logic        r_sign_a;
  logic        r_sign_b;
  // Multiply: running 64-bit product. Divide: {remainder, dividend->quotient}.
  logic [63:0] r_acc;
  // Multiply only: multiplicand shifted left one place per step.
  logic [63:0] r_mcand;
  // Multiply: multiplier bits still to consume. Divide: divisor (static).
  word_t       r_opb;
  word_t       r_hi;
  word_t       r_lo;

  logic        w_busy;
  logic        w_done;
  logic        w_is_div;
  logic        w_signed;
  logic        w_neg;
  logic        w_exit;
  word_t       w_mag_a;
  word_t       w_mag_b;
  logic [63:0] w_mul_acc;
  word_t       w_opb_shift;
  logic [32:0] w_rem_sh;
  logic [32:0] w_diff;
  logic [63:0] w_div_acc;
  logic [63:0] w_prod;
  word_t       w_quot;
  word_t       w_rem;
  word_t       w_res_hi;
  word_t       w_res_lo;

  assign w_is_div = op_is_div(r_op);
  assign w_signed = op_is_signed(r_op);
  assign w_neg    = r_sign_a ^ r_sign_b;

  assign w_mag_a  = magnitude(bus.port_A, op_is_signed(bus.mduop));
  assign w_mag_b  = magnitude(bus.port_B, op_is_signed(bus.mduop));

  // Shift-add step: add the multiplicand when the current multiplier bit is set.
  assign w_mul_acc   = r_acc + (r_opb[0] ? r_mcand : 64'd0);
  assign w_opb_shift = r_opb >> 1;

  // Restoring divide step. The shifted remainder needs 33 bits because the
  // remainder before the shift can be as large as divisor-1 (up to 2^32-2).
  assign w_rem_sh  = r_acc[63:31];
  assign w_diff    = w_rem_sh - {1'b0, r_opb};
  assign w_div_acc = w_diff[32] ? {w_rem_sh[31:0], r_acc[30:0], 1'b0}
                                : {w_diff[31:0],   r_acc[30:0], 1'b1};

`ifdef MDU_EARLY_OUT_EN
  assign w_exit = (r_cnt == 6'd31) || (!w_is_div && (w_opb_shift == '0));
`else
  assign w_exit = (r_cnt == 6'd31);
`endif

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses non-blocking assignments, and RST is tested
  // inside the clocked block so the reset is synchronous.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // ---------------- FSM: next-state logic ----------------
  // NOTE: every signal assigned in a combinational block gets a default first
  // so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_next = ST_CALC;
      ST_CALC: if (w_exit)    w_next = ST_FIN;
      ST_FIN:                 w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_CALC: w_busy = 1'b1;
      ST_FIN: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- Sign fixup of the final result ----------------
  always_comb begin
    w_prod   = (r_op == MDU_MULT && w_neg) ? -r_acc : r_acc;
    w_quot   = (r_op == MDU_DIV && w_neg) ? -r_acc[31:0] : r_acc[31:0];
    w_rem    = (w_signed && r_sign_a) ? -r_acc[63:32] : r_acc[63:32];
    w_res_hi = w_prod[63:32];
    w_res_lo = w_prod[31:0];
    if (w_is_div) begin
      // A zero divisor leaves the dividend magnitude as remainder, so the
      // remainder fixup already restores the original port_A; only the
      // quotient needs forcing to all ones.
      w_res_hi = w_rem;
      w_res_lo = (r_opb == '0) ? '1 : w_quot;
    end
  end

  // ---------------- Datapath and HI/LO ----------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt    <= '0;
      r_op     <= MDU_MULT;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_opb    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            // A write arriving with start is dropped: start takes priority.
            r_op     <= bus.mduop;
            r_sign_a <= bus.port_A[31];
            r_sign_b <= bus.port_B[31];
            r_cnt    <= '0;
            r_opb    <= w_mag_b;
            if (op_is_div(bus.mduop)) begin
              r_acc   <= {32'd0, w_mag_a};
              r_mcand <= '0;
            end else begin
              r_acc   <= '0;
              r_mcand <= {32'd0, w_mag_a};
            end
          end else begin
            if (bus.hi_wen) r_hi <= bus.wdata;
            if (bus.lo_wen) r_lo <= bus.wdata;
          end
        end
        ST_CALC: begin
          r_cnt <= r_cnt + 6'd1;
          if (w_is_div) begin
            r_acc <= w_div_acc;
          end else begin
            r_acc   <= w_mul_acc;
            r_mcand <= r_mcand << 1;
            r_opb   <= w_opb_shift;
          end
        end
        ST_FIN: begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// ---------------------------------------------------------------------------
// tb_mdu -- self-checking bench for mdu. Directed operations push their
// hand-computed results into a queue; a monitor pops one entry per done
// pulse and compares latency and the hi/lo values that follow it.
// ---------------------------------------------------------------------------
module tb_mdu;
  import cpu_types_pkg::*;

  typedef struct {
    string name;
    word_t hi;
    word_t lo;
    int    start_edge;
    int    lat;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  int    done_count = 0;
  exp_t  sb[$];

  mdu_if bus ();

  mdu dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far; at a falling edge it names the
  // rising edge that just happened.
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Edges from the start edge to the falling edge where done is high.
  function automatic int exp_lat(input mdu_op_t op, input word_t b);
    word_t mb;
    int    n;
    int    lat;
    lat = 32;
    mb  = (op == MDU_MULT && b[31]) ? -b : b;
    n   = 1;
    for (int i = 0; i < 32; i++) if (mb[i]) n = i + 1;
`ifdef MDU_EARLY_OUT_EN
    if (!op[1]) lat = n;
`endif
    return lat;
  endfunction

  // Drives start for exactly one cycle; returns at the falling edge after the
  // start edge, whose number is returned in s.
  task automatic issue(input string name, input mdu_op_t op, input word_t a, input word_t b,
                       input word_t ehi, input word_t elo, output int s);
    exp_t e;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mduop  = op;
    bus.port_A = a;
    bus.port_B = b;
    e.name       = name;
    e.hi         = ehi;
    e.lo         = elo;
    e.start_edge = cyc + 1;
    e.lat        = exp_lat(op, b);
    s            = e.start_edge;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, 64'(bus.busy), 64'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run_op(input string name, input mdu_op_t op, input word_t a, input word_t b,
                        input word_t ehi, input word_t elo);
    int s;
    issue(name, op, a, b, ehi, elo, s);
    wait_idle(name);
  endtask

  // Monitor: one scoreboard entry per done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        done_count++;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: done high at edge %0d, expected no pulse", cyc);
        end else begin
          e = sb.pop_front();
          check({e.name, "_latency"}, 64'(cyc - e.start_edge), 64'(e.lat));
          @(posedge clk);
          #1;
          check({e.name, "_hi"}, 64'(bus.hi), 64'(e.hi));
          check({e.name, "_lo"}, 64'(bus.lo), 64'(e.lo));
        end
      end
    end
  end

  initial begin
    int s;
    int dc;
    bus.start  = 1'b0;
    bus.mduop  = MDU_MULT;
    bus.port_A = '0;
    bus.port_B = '0;
    bus.hi_wen = 1'b0;
    bus.lo_wen = 1'b0;
    bus.wdata  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi",   64'(bus.hi),   64'd0);
    check("rst_lo",   64'(bus.lo),   64'd0);
    rst = 1'b0;

    // Arithmetic vectors
    run_op("mult_neg2x3",   MDU_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu_big2x3",  MDU_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA);
    run_op("div_m7_2",      MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_min_m1",    MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("divu_7_0",      MDU_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF);
    run_op("div_m7_0",      MDU_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op("mult_max_sq",   MDU_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001);
    run_op("multu_ones_sq", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_m1x1",     MDU_MULT,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("divu_100_7",    MDU_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E);
    run_op("div_7_m2",      MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);

    // MTHI alone, then MTHI and MTLO together
    @(negedge clk);
    bus.hi_wen = 1'b1;
    bus.wdata  = 32'h00001234;
    @(negedge clk);
    bus.hi_wen = 1'b0;
    check("mthi", 64'(bus.hi), 64'h1234);
    bus.hi_wen = 1'b1;
    bus.lo_wen = 1'b1;
    bus.wdata  = 32'h5555AAAA;
    @(negedge clk);
    bus.hi_wen = 1'b0;
    bus.lo_wen = 1'b0;
    check("mthi_both", 64'(bus.hi), 64'h5555AAAA);
    check("mtlo_both", 64'(bus.lo), 64'h5555AAAA);

    // MTLO and a second start while busy are both ignored
    issue("multu_busy", MDU_MULTU, 32'd5, 32'h40000000, 32'h00000001, 32'h40000000, s);
    check("busy_after_start", 64'(bus.busy), 64'd1);
    repeat (3) @(negedge clk);
    bus.start  = 1'b1;
    bus.mduop  = MDU_MULTU;
    bus.port_A = 32'd9;
    bus.port_B = 32'd9;
    bus.lo_wen = 1'b1;
    bus.wdata  = 32'h0000BEEF;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.lo_wen = 1'b0;
    check("mtlo_while_busy", 64'(bus.lo), 64'h5555AAAA);
    check("busy_after_restart", 64'(bus.busy), 64'd1);
    wait_idle("multu_busy");

    // start together with a write in IDLE: the write is discarded
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mduop  = MDU_MULTU;
    bus.port_A = 32'd2;
    bus.port_B = 32'd3;
    bus.hi_wen = 1'b1;
    bus.wdata  = 32'h0000DEAD;
    begin
      exp_t e;
      e.name       = "multu_with_write";
      e.hi         = 32'd0;
      e.lo         = 32'd6;
      e.start_edge = cyc + 1;
      e.lat        = exp_lat(MDU_MULTU, 32'd3);
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start  = 1'b0;
    bus.hi_wen = 1'b0;
    check("write_with_start_hi", 64'(bus.hi), 64'h1);
    wait_idle("multu_with_write");

    // start in the same cycle as RST is ignored
    @(negedge clk);
    rst        = 1'b1;
    bus.start  = 1'b1;
    bus.mduop  = MDU_MULT;
    bus.port_A = 32'd3;
    bus.port_B = 32'd3;
    @(negedge clk);
    check("start_with_rst_busy", 64'(bus.busy), 64'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("start_with_rst_busy_after", 64'(bus.busy), 64'd0);
    check("start_with_rst_hi", 64'(bus.hi), 64'd0);

    // Reset in the middle of an operation
    @(negedge clk);
    bus.hi_wen = 1'b1;
    bus.lo_wen = 1'b1;
    bus.wdata  = 32'h11112222;
    @(negedge clk);
    bus.hi_wen = 1'b0;
    bus.lo_wen = 1'b0;
    issue("mult_aborted", MDU_MULT, 32'h12345678, 32'h7FFFFFFF, 32'd0, 32'd0, s);
    while (cyc < s + 9) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    dc = done_count;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_hi",   64'(bus.hi),   64'd0);
    check("abort_lo",   64'(bus.lo),   64'd0);
    repeat (40) @(negedge clk);
    check("abort_no_done", 64'(done_count), 64'(dc));

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
